// File: rtl/retire_checker.sv
// retire_checker
//
// Watches a hart's retire interface and checks every retired instruction for
// architectural consistency: PC continuity, source operand values against a
// shadow register file, next-PC alignment and traps. A watchdog fails the run
// if no instruction retires for TIMEOUT consecutive cycles. The first failure,
// or a retired ebreak, is latched and held until rst.
//
// Parameters
//   RESET_ADDR  PC expected for the first retired instruction
//   TIMEOUT     consecutive non-retire cycles that trigger a timeout (>= 1)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   i_retire_valid                 an instruction retires this cycle
//   i_retire_inst                  instruction word (debug only, not checked)
//   i_retire_trap / i_retire_halt  instruction trapped / is ebreak
//   i_retire_rs{1,2}_raddr/_rdata  source register addresses and data
//   i_retire_rd_waddr/_wdata       destination register (0 = none) and data
//   i_retire_pc / i_retire_next_pc PC and next PC of the retiring instruction
//   o_state                        0 = RUN, 1 = HALT, 2 = FAIL
//   o_done / o_error               state is HALT or FAIL / state is FAIL
//   o_err_code                     first failure cause (0 = none .. 6 = timeout)
//   o_err_pc                       PC associated with the first failure
//   o_retire_count                 instructions accepted so far
module retire_checker #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_retire_valid,
    input  logic [31:0] i_retire_inst,
    input  logic        i_retire_trap,
    input  logic        i_retire_halt,
    input  logic [4:0]  i_retire_rs1_raddr,
    input  logic [4:0]  i_retire_rs2_raddr,
    input  logic [31:0] i_retire_rs1_rdata,
    input  logic [31:0] i_retire_rs2_rdata,
    input  logic [4:0]  i_retire_rd_waddr,
    input  logic [31:0] i_retire_rd_wdata,
    input  logic [31:0] i_retire_pc,
    input  logic [31:0] i_retire_next_pc,
    output logic [1:0]  o_state,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_err_code,
    output logic [31:0] o_err_pc,
    output logic [31:0] o_retire_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_PC      = 3'd1,
        ERR_RS1     = 3'd2,
        ERR_RS2     = 3'd3,
        ERR_ALIGN   = 3'd4,
        ERR_TRAP    = 3'd5,
        ERR_TIMEOUT = 3'd6
    } err_t;

    // Watchdog value seen on the last idle cycle before the timeout fires.
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    err_t        err_code;
    err_t        check_code;
    logic [31:0] err_pc;
    logic [31:0] retire_count;
    logic [31:0] expected_pc;
    logic [31:0] watchdog;
    logic [31:0] shadow [32];
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    // The instruction word is carried for debug only.
    logic unused_inst;
    assign unused_inst = ^i_retire_inst;

    // Source checks read the pre-update shadow, so an instruction whose rd
    // matches a source is compared against the old value.
    assign rs1_val = (i_retire_rs1_raddr == 5'd0) ? 32'd0 : shadow[i_retire_rs1_raddr];
    assign rs2_val = (i_retire_rs2_raddr == 5'd0) ? 32'd0 : shadow[i_retire_rs2_raddr];

    // Checks in priority order; the first failing one names the error.
    always_comb begin
        // NOTE: default assignment first so every path drives check_code and no latch is inferred.
        check_code = ERR_NONE;
        if (i_retire_pc != expected_pc)
            check_code = ERR_PC;
        else if (i_retire_rs1_rdata != rs1_val)
            check_code = ERR_RS1;
        else if (i_retire_rs2_rdata != rs2_val)
            check_code = ERR_RS2;
        else if (i_retire_next_pc[1:0] != 2'b00)
            check_code = ERR_ALIGN;
        else if (i_retire_trap)
            check_code = ERR_TRAP;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            err_code     <= ERR_NONE;
            err_pc       <= '0;
            retire_count <= '0;
            expected_pc  <= RESET_ADDR;
            watchdog     <= '0;
            // NOTE: the shadow file is reset too; source checks after rst must see zeros, not stale data.
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else if (state == ST_RUN) begin
            if (i_retire_valid) begin
                watchdog <= '0;
                if (check_code != ERR_NONE) begin
                    state    <= ST_FAIL;
                    err_code <= check_code;
                    err_pc   <= i_retire_pc;
                end else begin
                    retire_count <= retire_count + 32'd1;
                    expected_pc  <= i_retire_next_pc;
                    if (i_retire_rd_waddr != 5'd0)
                        shadow[i_retire_rd_waddr] <= i_retire_rd_wdata;
                    if (i_retire_halt)
                        state <= ST_HALT;
                end
            end else begin
                watchdog <= watchdog + 32'd1;
                if (watchdog == WDOG_LAST) begin
                    state    <= ST_FAIL;
                    err_code <= ERR_TIMEOUT;
                    err_pc   <= expected_pc;
                end
            end
        end
        // HALT and FAIL hold every register until rst.
    end

    assign o_state        = state;
    assign o_done         = (state == ST_HALT) || (state == ST_FAIL);
    assign o_error        = (state == ST_FAIL);
    assign o_err_code     = err_code;
    assign o_err_pc       = err_pc;
    assign o_retire_count = retire_count;

endmodule

// File: tb/tb_retire_checker.sv
// Self-checking bench for retire_checker: directed scenarios followed by
// randomized segments, all compared against a behavioural model of the
// checker's rules (register array, expected PC, idle counter, status).
module tb_retire_checker;

    localparam int unsigned TO = 4;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        trap;
        logic        halt;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] inst = '0;
    logic        trap = 1'b0;
    logic        halt = 1'b0;
    logic [4:0]  rs1_a = '0, rs2_a = '0, rd_a = '0;
    logic [31:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
    logic [31:0] pc = '0, next_pc = '0;
    logic [1:0]  state;
    logic        done, error;
    logic [2:0]  err_code;
    logic [31:0] err_pc, count;

    retire_checker #(.RESET_ADDR(32'h0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_retire_valid(valid), .i_retire_inst(inst),
        .i_retire_trap(trap), .i_retire_halt(halt),
        .i_retire_rs1_raddr(rs1_a), .i_retire_rs2_raddr(rs2_a),
        .i_retire_rs1_rdata(rs1_d), .i_retire_rs2_rdata(rs2_d),
        .i_retire_rd_waddr(rd_a), .i_retire_rd_wdata(rd_d),
        .i_retire_pc(pc), .i_retire_next_pc(next_pc),
        .o_state(state), .o_done(done), .o_error(error),
        .o_err_code(err_code), .o_err_pc(err_pc), .o_retire_count(count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural view of what the checker should report.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc, m_count, m_err_pc;
    int          m_state, m_code, m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic ret_t mk(input logic [31:0] p, input logic [31:0] np,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] a2, input logic [31:0] d2,
                                input logic [4:0] rd, input logic [31:0] wd,
                                input logic tr, input logic hl);
        ret_t r;
        r.v = 1'b1; r.pc = p; r.npc = np; r.a1 = a1; r.d1 = d1; r.a2 = a2; r.d2 = d2;
        r.rd = rd; r.wd = wd; r.trap = tr; r.halt = hl;
        return r;
    endfunction

    function automatic ret_t idle_ret();
        ret_t r;
        r = mk($urandom, $urandom, 5'($urandom), $urandom, 5'($urandom), $urandom,
               5'($urandom), $urandom, 1'($urandom), 1'($urandom));
        r.v = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0; m_count = '0; m_err_pc = '0;
        m_state = 0; m_code = 0; m_idle = 0;
    endtask

    task automatic model_fail(input int code, input logic [31:0] p);
        m_state = 2; m_code = code; m_err_pc = p;
    endtask

    task automatic model_apply(input ret_t r);
        logic [31:0] src1, src2;
        if (m_state != 0) return;
        if (!r.v) begin
            m_idle++;
            if (m_idle == TO) model_fail(6, m_pc);
            return;
        end
        m_idle = 0;
        src1 = (r.a1 == 0) ? 32'd0 : m_regs[r.a1];
        src2 = (r.a2 == 0) ? 32'd0 : m_regs[r.a2];
        if (r.pc != m_pc)                  model_fail(1, r.pc);
        else if (r.d1 != src1)             model_fail(2, r.pc);
        else if (r.d2 != src2)             model_fail(3, r.pc);
        else if (r.npc % 4 != 0)           model_fail(4, r.pc);
        else if (r.trap)                   model_fail(5, r.pc);
        else begin
            m_count++;
            m_pc = r.npc;
            if (r.rd != 0) m_regs[r.rd] = r.wd;
            if (r.halt) m_state = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".done"},  32'(done),  32'(m_state != 0));
        check({tag, ".error"}, 32'(error), 32'(m_state == 2));
        check({tag, ".code"},  32'(err_code), 32'(m_code));
        check({tag, ".errpc"}, err_pc, m_err_pc);
        check({tag, ".count"}, count, m_count);
    endtask

    task automatic drive(input ret_t r);
        valid = r.v; pc = r.pc; next_pc = r.npc; rs1_a = r.a1; rs1_d = r.d1;
        rs2_a = r.a2; rs2_d = r.d2; rd_a = r.rd; rd_d = r.wd;
        trap = r.trap; halt = r.halt; inst = $urandom;
    endtask

    task automatic step(input ret_t r, input string tag);
        drive(r);
        @(posedge clk);
        model_apply(r);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        drive(mk(32'h4, 32'h8, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3, 1'b0, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        compare_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        ret_t r;
        model_reset();

        // Reset values, checked against literal constants.
        do_reset("rst0");
        check("rst0.state_c", 32'(state), 32'd0);
        check("rst0.count_c", count, 32'd0);

        // Clean run ending in ebreak.
        step(mk(32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5,  1'b0, 1'b0), "clean.addi");
        step(mk(32'h4, 32'h8, 5'd1, 32'd5, 5'd1, 32'd5, 5'd2, 32'd10, 1'b0, 1'b0), "clean.add");
        step(mk(32'h8, 32'hC, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,  1'b0, 1'b1), "clean.ebreak");
        check("clean.count_c", count, 32'd3);
        check("clean.state_c", 32'(state), 32'd1);
        check("clean.done_c",  32'(done), 32'd1);
        check("clean.error_c", 32'(error), 32'd0);
        step(mk(32'hC, 32'h10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0), "clean.frozen");

        // Stale source read.
        do_reset("stale.rst");
        step(mk(32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 1'b0, 1'b0), "stale.w");
        step(mk(32'h4, 32'h8, 5'd1, 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0), "stale.r");
        check("stale.code_c",  32'(err_code), 32'd2);
        check("stale.errpc_c", err_pc, 32'h4);
        check("stale.count_c", count, 32'd1);

        // rd equal to rs1: compared against the old value.
        do_reset("same.rst");
        step(mk(32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'd7, 1'b0, 1'b0), "same.w");
        step(mk(32'h4, 32'h8, 5'd3, 32'd7, 5'd0, 32'd0, 5'd3, 32'd8, 1'b0, 1'b0), "same.rw");
        step(mk(32'h8, 32'hC, 5'd3, 32'd8, 5'd3, 32'd8, 5'd0, 32'd0, 1'b0, 1'b0), "same.r");
        check("same.error_c", 32'(error), 32'd0);
        check("same.count_c", count, 32'd3);

        // PC discontinuity.
        do_reset("pc.rst");
        step(mk(32'h0,  32'h10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0), "pc.a");
        step(mk(32'h14, 32'h18, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0), "pc.b");
        check("pc.code_c",  32'(err_code), 32'd1);
        check("pc.errpc_c", err_pc, 32'h14);

        // Misaligned next_pc.
        do_reset("align.rst");
        step(mk(32'h0, 32'h22, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd1, 1'b0, 1'b0), "align.a");
        check("align.code_c", 32'(err_code), 32'd4);

        // Trap together with halt: failure wins.
        do_reset("trap.rst");
        step(mk(32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd1, 1'b1, 1'b1), "trap.a");
        check("trap.code_c",  32'(err_code), 32'd5);
        check("trap.state_c", 32'(state), 32'd2);

        // rs2 mismatch only.
        do_reset("rs2.rst");
        step(mk(32'h0, 32'h4, 5'd0, 32'd0, 5'd5, 32'd9, 5'd0, 32'd0, 1'b0, 1'b0), "rs2.a");
        check("rs2.code_c", 32'(err_code), 32'd3);

        // Timeout then freeze.
        do_reset("to.rst");
        step(mk(32'h0, 32'h40, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0), "to.ret");
        for (int i = 0; i < 3; i++) step(idle_ret(), "to.idle");
        check("to.pre_state_c", 32'(state), 32'd0);
        step(idle_ret(), "to.fire");
        check("to.code_c",  32'(err_code), 32'd6);
        check("to.errpc_c", err_pc, 32'h40);
        step(mk(32'h40, 32'h44, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0), "to.frozen");
        check("to.count_c", count, 32'd1);
        check("to.code2_c", 32'(err_code), 32'd6);

        // Reset mid-run clears the shadow file.
        do_reset("mid.rst0");
        for (int i = 0; i < 5; i++)
            step(mk(32'(4 * i), 32'(4 * i + 4), 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd9, 1'b0, 1'b0), "mid.ret");
        do_reset("mid.rst1");
        check("mid.count_c", count, 32'd0);
        step(mk(32'h0, 32'h4, 5'd1, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0), "mid.x1");
        check("mid.error_c", 32'(error), 32'd0);
        check("mid.count1_c", count, 32'd1);

        // Randomized segments: mostly legal traffic with occasional faults.
        for (int seg = 0; seg < 25; seg++) begin
            do_reset("rnd.rst");
            for (int cyc = 0; cyc < 150; cyc++) begin
                if ($urandom_range(0, 9) == 0) begin
                    r = idle_ret();
                end else begin
                    r.v  = 1'b1;
                    r.pc = ($urandom_range(0, 59) == 0) ? m_pc + 32'd4 : m_pc;
                    r.a1 = 5'($urandom);
                    r.a2 = 5'($urandom);
                    r.d1 = ($urandom_range(0, 59) == 0) ? $urandom : m_regs[r.a1];
                    r.d2 = ($urandom_range(0, 59) == 0) ? $urandom : m_regs[r.a2];
                    if (r.a1 == 0 && r.d1 != 0 && $urandom_range(0, 1) == 0) r.d1 = '0;
                    if (r.a2 == 0 && r.d2 != 0 && $urandom_range(0, 1) == 0) r.d2 = '0;
                    case ($urandom_range(0, 59))
                        0:       r.npc = m_pc + 32'd2;
                        1, 2, 3: r.npc = $urandom & 32'hFFFF_FFFC;
                        default: r.npc = m_pc + 32'd4;
                    endcase
                    r.rd   = 5'($urandom);
                    r.wd   = $urandom;
                    r.trap = ($urandom_range(0, 79) == 0);
                    r.halt = ($urandom_range(0, 79) == 0);
                end
                step(r, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/retire_checker.md
# retire_checker

Consumes the hart's retire interface and checks each retired instruction for architectural consistency. It holds a shadow register file that is updated from retire writebacks, tracks the expected PC, and runs a no-retire watchdog. It reports pass, halt, or first failure to the testbench. It sits beside the hart and drives nothing back into it.

## Interface
- RESET_ADDR, 32'h00000000, PC expected for the first retired instruction
- TIMEOUT, 1024, consecutive cycles without a retire before a timeout failure (>=1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_retire_valid  in  1  instruction retiring this cycle; all other i_retire_* are ignored when low
- i_retire_inst  in  32  instruction word (carried for debug only, not checked)
- i_retire_trap  in  1  instruction trapped
- i_retire_halt  in  1  instruction is ebreak
- i_retire_rs1_raddr, i_retire_rs2_raddr  in  5  source register addresses
- i_retire_rs1_rdata, i_retire_rs2_rdata  in  32  source register data
- i_retire_rd_waddr  in  5  destination register (0 = no write)
- i_retire_rd_wdata  in  32  destination data
- i_retire_pc, i_retire_next_pc  in  32  PC and next PC of the retiring instruction
- o_state  out  2  0=RUN, 1=HALT, 2=FAIL
- o_done  out  1  state is HALT or FAIL
- o_error  out  1  state is FAIL
- o_err_code  out  3  0 none, 1 pc mismatch, 2 rs1 mismatch, 3 rs2 mismatch, 4 misaligned next_pc, 5 trap, 6 timeout
- o_err_pc  out  32  PC associated with the failure
- o_retire_count  out  32  number of instructions accepted

## Operation
- Shadow regfile: 32x32. x0 always reads 0. All entries reset to 0.
- expected_pc register: resets to RESET_ADDR.
- In RUN, each cycle with i_retire_valid=1 is checked in priority order. The first failing check sets err_code.
  - 1: i_retire_pc != expected_pc
  - 2: i_retire_rs1_rdata != shadow[rs1_raddr] (shadow[0]=0)
  - 3: same comparison for rs2
  - 4: i_retire_next_pc[1:0] != 0
  - 5: i_retire_trap=1
- Any failure:
  - state goes to FAIL; o_err_pc = i_retire_pc.
  - The instruction is not counted; shadow and expected_pc are not updated.
- Pass:
  - o_retire_count += 1 (wraps at 2^32).
  - expected_pc = i_retire_next_pc.
  - If rd_waddr != 0, shadow[rd_waddr] = rd_wdata.
  - If i_retire_halt=1, state goes to HALT. The halt instruction is itself counted and its writeback applied.
- Source checks use pre-update shadow values. An instruction whose rd equals its rs1 or rs2 is compared against the old value.
- Watchdog (32-bit counter): cleared on any valid retire; in RUN, increments on each cycle with i_retire_valid=0.
  - When TIMEOUT consecutive non-retire cycles have elapsed, state goes to FAIL with err_code 6 and o_err_pc = expected_pc.
- HALT and FAIL are terminal until rst. Retire inputs are ignored there, and all outputs and the watchdog are frozen.
- o_done and o_error are decoded from the state register.

## Timing
- All outputs are registered. The effect of a retire at cycle N is visible after the rising edge that ends cycle N.
- Checks are combinational on the inputs and committed at that edge. There is no backpressure; one retire per cycle is sustained.
- Reset values: o_state=RUN(0), o_done=0, o_error=0, o_err_code=0, o_err_pc=0, o_retire_count=0, expected_pc=RESET_ADDR, shadow=0, watchdog=0.
- rst mid-run or in a terminal state: everything returns to reset values at that edge, including the shadow. Inputs during rst cycles are ignored.
- Timeout example: with TIMEOUT=3, valid low for cycles 0, 1 and 2 after reset. FAIL is visible after the edge ending cycle 2.
- A halt and a failing check on the same instruction: FAIL wins and the halt is ignored.
- Only the first failure is latched; later events cannot change err_code or err_pc.

## Test plan
- Clean run:
  - Stimulus: RESET_ADDR=0; retire addi x1 (pc 0, next 4, rd=1, wdata 5), then add x2,x1,x1 (pc 4, rs1=rs2=1, rdata 5, rd=2, wdata 10), then ebreak (pc 8).
  - Required: count=3, state HALT, o_done=1, o_error=0.
- Stale read:
  - Stimulus: after x1=5, retire an instruction at the correct pc with rs1=1 and rs1_rdata=4.
  - Required: FAIL, code 2, err_pc = that pc, count unchanged.
- Same-register read/write:
  - Stimulus: x3=7, then retire addi x3,x3,1 with rs1_rdata=7, wdata=8; next instruction reads x3 with rdata 8.
  - Required: no error, count +2.
- PC continuity and next_pc checks:
  - Stimulus: after next_pc=0x10, retire pc=0x14.
  - Required: FAIL code 1, err_pc=0x14.
  - Stimulus (separate run): retire with next_pc=0x22.
  - Required: FAIL code 4.
- Timeout and freeze:
  - Stimulus: TIMEOUT=4, one retire, then 4 idle cycles.
  - Required: FAIL code 6, err_pc = that retire's next_pc; a subsequent valid retire leaves count and err_code unchanged.
- Reset mid-run:
  - Stimulus: assert rst after 5 retires.
  - Required: all outputs at reset values after one edge; next retire reading x1 must carry rdata 0 to pass.
